// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared constants and types for the servo PWM path. The PWM generator and the
// position ramp both take PERIOD from here, so their period counters cannot
// drift apart.
//   WIDTH       : width of compare / counter values
//   PERIOD      : terminal count of the PWM period counter (runs 0..PERIOD)
//   ANGLE_W     : command angle width
//   ANGLE_MAX   : largest legal angle in degrees
//   CMP_MIN     : compare value at 0 deg (1 ms pulse)
//   K           : angle scale, compare = CMP_MIN + ((angle*K) >> 8)
//   STEP        : largest compare change per PWM period
//   CMP_NEUTRAL : compare value at 90 deg
// -----------------------------------------------------------------------------
package servo_pkg;

    localparam int WIDTH     = 12;
    localparam int PERIOD    = 3126;
    localparam int ANGLE_W   = 8;
    localparam int ANGLE_MAX = 180;
    localparam int CMP_MIN   = 156;
    localparam int K         = 222;
    localparam int STEP      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Angle (degrees) to compare value, truncating the scaled product.
    function automatic int angle_to_cmp(input int angle_deg, input int cmp_min, input int k);
        return cmp_min + ((angle_deg * k) >> 8);
    endfunction

    localparam int CMP_NEUTRAL = angle_to_cmp(90, CMP_MIN, K);  // 234

endpackage

// File: rtl/servo_angle_mul.sv
// -----------------------------------------------------------------------------
// servo_angle_mul
// Sequential shift-add multiplier: scaled = (angle * K) >> 8.
// MSB-first: each cycle the accumulator doubles and adds K when the current
// angle bit is set, so ANGLE_W cycles after i_start the product is complete.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_start    : load i_angle and clear the accumulator (one-cycle pulse)
//   i_angle    : multiplicand, already clamped by the caller
//   o_done     : high during the final shift-add step; o_scaled is valid
//                from the following cycle until the next i_start
//   o_scaled   : upper ANGLE_W bits of the ANGLE_W+8 bit product
// -----------------------------------------------------------------------------
module servo_angle_mul
    import servo_pkg::*;
#(
    parameter int ANGLE_W = servo_pkg::ANGLE_W,
    parameter int K       = servo_pkg::K
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [ANGLE_W-1:0] i_angle,
    output logic               o_done,
    output logic [ANGLE_W-1:0] o_scaled
);

    // ANGLE_W+8 bits holds (2^ANGLE_W - 1) * K for any K below 256.
    localparam int ACC_W = ANGLE_W + 8;
    localparam int CNT_W = (ANGLE_W > 1) ? $clog2(ANGLE_W) : 1;
    localparam logic [ACC_W-1:0] K_ACC    = ACC_W'(K);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ANGLE_W - 1);

    logic [ANGLE_W-1:0] r_a;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_a    <= i_angle;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= {r_acc[ACC_W-2:0], 1'b0} + (r_a[ANGLE_W-1] ? K_ACC : '0);
            r_a   <= {r_a[ANGLE_W-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done   = r_busy && (r_cnt == LAST_CNT);
    assign o_scaled = r_acc[ACC_W-1:8];

endmodule

// File: rtl/servo_pos_ramp.sv
// -----------------------------------------------------------------------------
// servo_pos_ramp
// Upstream stage of the servo PWM generator. Accepts angle commands over a
// valid/ready handshake, converts each to a compare target, and slews cmp_out
// toward that target by at most STEP per PWM period. cmp_out is written only
// on the period tick, which lines up with the generator's own counter, so a
// pulse is never cut short or stretched mid-period.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : angle command valid
//   in_angle   : commanded angle in degrees
//   in_ready   : command can be accepted (IDLE only)
//   cmp_out    : compare value delivered to the PWM generator
//   at_target  : cmp_out equals the current target
//   err_range  : last accepted angle exceeded ANGLE_MAX (held until next)
// -----------------------------------------------------------------------------
module servo_pos_ramp
    import servo_pkg::*;
#(
    parameter int WIDTH     = servo_pkg::WIDTH,
    parameter int PERIOD    = servo_pkg::PERIOD,
    parameter int ANGLE_W   = servo_pkg::ANGLE_W,
    parameter int ANGLE_MAX = servo_pkg::ANGLE_MAX,
    parameter int CMP_MIN   = servo_pkg::CMP_MIN,
    parameter int K         = servo_pkg::K,
    parameter int STEP      = servo_pkg::STEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [ANGLE_W-1:0] in_angle,
    output logic               in_ready,
    output logic [WIDTH-1:0]   cmp_out,
    output logic               at_target,
    output logic               err_range
);

    localparam logic [WIDTH-1:0]   NEUTRAL_CMP = WIDTH'(angle_to_cmp(90, CMP_MIN, K));
    localparam logic [WIDTH-1:0]   PERIOD_CNT  = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0]   STEP_CMP    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0]   MIN_CMP     = WIDTH'(CMP_MIN);
    localparam logic [ANGLE_W-1:0] ANGLE_LIMIT = ANGLE_W'(ANGLE_MAX);

    state_t             r_state;
    logic               r_ready;
    logic               r_err;
    logic [WIDTH-1:0]   r_target;
    logic [WIDTH-1:0]   r_cmp;
    logic [WIDTH-1:0]   r_count;

    logic               w_tick;
    logic               w_accept;
    logic               w_over;
    logic               w_mul_done;
    logic [ANGLE_W-1:0] w_angle_sat;
    logic [ANGLE_W-1:0] w_scaled;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;

    assign w_tick      = (r_count == PERIOD_CNT);
    assign w_accept    = in_valid & r_ready;
    assign w_over      = (in_angle > ANGLE_LIMIT);
    assign w_angle_sat = w_over ? ANGLE_LIMIT : in_angle;

    servo_angle_mul #(
        .ANGLE_W (ANGLE_W),
        .K       (K)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept),
        .i_angle  (w_angle_sat),
        .o_done   (w_mul_done),
        .o_scaled (w_scaled)
    );

    // Period counter: mirrors the PWM generator's counter, 0..PERIOD.
    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Command FSM. The multiplier is started by the accept itself, so MUL
    // lasts exactly as long as the multiplier's ANGLE_W steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_err    <= 1'b0;
            r_target <= NEUTRAL_CMP;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_err   <= w_over;
                        r_ready <= 1'b0;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_target <= MIN_CMP + WIDTH'(w_scaled);
                    r_ready  <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Ramp. Reads r_target before any same-cycle LOAD lands, so a LOAD on a
    // tick only takes effect at the following tick. Retargeting mid-ramp
    // continues from the current cmp_out, so there is never a jump.
    assign w_rise = r_target - r_cmp;
    assign w_fall = r_cmp - r_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp <= NEUTRAL_CMP;
        end else if (w_tick) begin
            if (r_target >= r_cmp) begin
                r_cmp <= (w_rise <= STEP_CMP) ? r_target : (r_cmp + STEP_CMP);
            end else begin
                r_cmp <= (w_fall <= STEP_CMP) ? r_target : (r_cmp - STEP_CMP);
            end
        end
    end

    assign in_ready  = r_ready;
    assign cmp_out   = r_cmp;
    assign err_range = r_err;
    assign at_target = (r_cmp == r_target);

endmodule

// File: tb/tb_servo_pos_ramp.sv
module tb_servo_pos_ramp;

    localparam int P = 99;  // shortened period: counter runs 0..99

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_angle = 8'd0;
    logic        in_ready;
    logic [11:0] cmp_out;
    logic        at_target;
    logic        err_range;

    servo_pos_ramp #(.PERIOD(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_angle  (in_angle),
        .in_ready  (in_ready),
        .cmp_out   (cmp_out),
        .at_target (at_target),
        .err_range (err_range)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works from elapsed clocks since reset and the angle formula; it knows
    // nothing of the DUT's states or registers.
    int m_cnt, m_ready_at, m_load_at, m_pend, m_target, m_cmp, m_err, m_diff;
    bit m_en = 1'b0;
    bit m_tick, m_rst_edge;
    int prev_cmp = 234;
    int chg_cnt = 0, last_delta = 0, off_tick = 0;

    function automatic int ref_target(input int ang);
        int a;
        a = (ang > 180) ? 180 : ang;
        return 156 + (a * 222) / 256;
    endfunction

    always begin
        @(posedge clk);
        m_rst_edge = rst;
        m_tick     = 1'b0;
        if (rst) begin
            m_cnt = 0; m_ready_at = 0; m_load_at = -1;
            m_target = 234; m_cmp = 234; m_err = 0; m_en = 1'b1;
        end else if (m_en) begin
            m_tick = ((m_cnt % (P + 1)) == P);
            if (in_valid && m_cnt >= m_ready_at) begin
                m_err      = (int'(in_angle) > 180) ? 1 : 0;
                m_pend     = ref_target(int'(in_angle));
                m_load_at  = m_cnt + 9;
                m_ready_at = m_cnt + 10;
            end
            if (m_tick) begin
                m_diff = m_target - m_cmp;
                if (m_diff > 2)       m_cmp = m_cmp + 2;
                else if (m_diff < -2) m_cmp = m_cmp - 2;
                else                  m_cmp = m_target;
            end
            if (m_cnt == m_load_at) m_target = m_pend;
            m_cnt++;
        end
        #1;
        if (m_en) begin
            check("cmp_out", cmp_out, m_cmp);
            check("at_target", at_target, (m_cmp == m_target) ? 1 : 0);
            check("in_ready", in_ready, (m_cnt >= m_ready_at) ? 1 : 0);
            check("err_range", err_range, m_err);
            check("cmp_in_range", (cmp_out >= 12'd156 && cmp_out <= 12'd312) ? 1 : 0, 1);
            if (int'(cmp_out) != prev_cmp) begin
                chg_cnt++;
                last_delta = (int'(cmp_out) > prev_cmp) ? int'(cmp_out) - prev_cmp
                                                        : prev_cmp - int'(cmp_out);
                if (!m_rst_edge && !m_tick) off_tick++;
            end
            prev_cmp = int'(cmp_out);
        end
    end

    // ---------------- helpers ----------------
    task automatic send(input int ang);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin @(negedge clk); w++; end
        check("send_ready", in_ready, 1);
        chg_cnt  = 0;
        in_valid = 1'b1;
        in_angle = ang[7:0];
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_settle(input int max_cycles);
        int n;
        n = 0;
        while (!(in_ready && at_target) && n < max_cycles) begin @(negedge clk); n++; end
        check("settle", (in_ready && at_target) ? 1 : 0, 1);
    endtask

    typedef struct {
        int angle;
        int exp_target;
        int exp_err;
        int exp_steps;
        int exp_last;
    } vec_t;

    vec_t vt[4];

    initial begin
        #1_500_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vt[0] = '{90,  234, 0, 39, 2};   // from 156
        vt[1] = '{45,  195, 0, 20, 1};   // 234 -> 196 -> 195
        vt[2] = '{200, 312, 1, 59, 1};   // out of range, clamped
        vt[3] = '{90,  234, 0, 39, 2};   // clears err_range

        // Reset state and stillness over 3 periods
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_cmp", cmp_out, 234);
        check("rst_at_target", at_target, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_err", err_range, 0);
        chg_cnt = 0;
        repeat (300) @(negedge clk);
        check("idle_changes", chg_cnt, 0);
        check("idle_cmp", cmp_out, 234);

        // 180 deg: 9-cycle busy window, 39 ticks to 312
        send(180);
        n = 0;
        while (!in_ready && n < 30) begin n++; @(negedge clk); end
        check("ready_low_cycles", n, 9);
        wait_settle(4500);
        check("ramp180_cmp", cmp_out, 312);
        check("ramp180_steps", chg_cnt, 39);
        check("ramp180_at_target", at_target, 1);

        // 0 deg from 312: down by 2 per tick, only on ticks
        off_tick = 0;
        send(0);
        wait_settle(8500);
        check("ramp0_cmp", cmp_out, 156);
        check("ramp0_steps", chg_cnt, 78);
        check("ramp0_off_tick_writes", off_tick, 0);

        // Table-driven commands
        for (int i = 0; i < 4; i++) begin
            send(vt[i].angle);
            wait_settle(vt[i].exp_steps * 100 + 300);
            check($sformatf("vec%0d_cmp", i), cmp_out, vt[i].exp_target);
            check($sformatf("vec%0d_err", i), err_range, vt[i].exp_err);
            check($sformatf("vec%0d_steps", i), chg_cnt, vt[i].exp_steps);
            check($sformatf("vec%0d_last_step", i), last_delta, vt[i].exp_last);
        end

        // in_valid held through MUL with changing angle: only 30 is used
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        chg_cnt  = 0;
        in_valid = 1'b1;
        in_angle = 8'd30;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            in_angle = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_settle(3500);
        check("hold_valid_cmp", cmp_out, 182);

        // LOAD coincident with tick: that tick still uses the old target
        n = 0;
        while ((m_cnt % (P + 1)) != 90 && n < 200) begin @(negedge clk); n++; end
        check("align_phase", m_cnt % (P + 1), 90);
        in_valid = 1'b1;
        in_angle = 8'd180;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("load_tick_cmp_old", cmp_out, 182);
        check("load_tick_at_target", at_target, 0);
        repeat (100) @(negedge clk);
        check("load_tick_next_step", cmp_out, 184);

        // Reset mid-MUL after a 180 command: command is dropped
        send(180);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chg_cnt = 0;
        check("midrst_cmp", cmp_out, 234);
        check("midrst_ready", in_ready, 1);
        check("midrst_at_target", at_target, 1);
        repeat (300) @(negedge clk);
        check("midrst_cmp_after", cmp_out, 234);
        check("midrst_changes", chg_cnt, 0);
        check("midrst_target_kept", at_target, 1);

        // Randomized commands, including retargets mid-ramp
        for (int i = 0; i < 9000; i++) begin
            in_valid = ($urandom_range(0, 119) == 0);
            in_angle = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("total_off_tick_writes", off_tick, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
